// File: rtl/calc_mem_bridge.sv
// Calculator-to-CPU shared-memory bridge: buffered calculator writes,
// 16-word mailbox with status word, and a result return handshake.
module calc_mem_bridge #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK_100MHZ,
    input  logic              reset,
    input  logic              calc_we,
    input  logic [32:0]       calc_addr,
    input  logic [DATA_W-1:0] calc_wdata,
    input  logic              calc_rd_req,
    output logic [DATA_W-1:0] calc_rdata,
    output logic              calc_result_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [2:0]        fifo_count,
    output logic              overflow
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] A_OPB = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_RES = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_ST  = ADDR_W'(15);

    logic              we_q;
    logic              rd_q;
    logic              we_rise;
    logic              rd_rise;
    logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] f_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [2:0]        count;
    logic [DATA_W-1:0] mem [WORDS];
    logic              full;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    logic [1:0]        st_nxt;
    logic              unused_addr;

    assign unused_addr = ^calc_addr[32:ADDR_W];

    assign we_rise = calc_we & ~we_q;
    assign rd_rise = calc_rd_req & ~rd_q;
    assign full    = (count == 3'(FIFO_DEPTH));
    assign pop     = (count != 3'd0) && !cpu_we;
    assign push    = we_rise && (!full || pop);
    assign h_addr  = f_addr[rd_ptr];
    assign h_data  = f_data[rd_ptr];

    assign fifo_count = count;

    // Previous-cycle copies of the calculator strobes for rise detection
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            we_q <= 1'b0;
            rd_q <= 1'b0;
        end else begin
            we_q <= calc_we;
            rd_q <= calc_rd_req;
        end
    end

    // Calculator write buffer: in-order queue, drops and flags when full
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_addr[i] <= '0;
                f_data[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                f_addr[wr_ptr] <= calc_addr[ADDR_W-1:0];
                f_data[wr_ptr] <= calc_wdata;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (we_rise && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Status word: later rules override earlier ones (set beats clear)
    always_comb begin
        st_nxt = mem[A_ST][1:0];
        if (pop && h_addr == A_ST) begin
            st_nxt = h_data[1:0];
        end
        if (cpu_we && cpu_addr == A_ST) begin
            st_nxt = cpu_wdata[1:0];
        end
        if (rd_rise) begin
            st_nxt[1] = 1'b0;
        end
        if (cpu_we && cpu_addr == A_RES) begin
            st_nxt[1] = 1'b1;
        end
        if (pop && h_addr == A_OPB) begin
            st_nxt[0] = 1'b1;
        end
    end

    // Mailbox port: CPU write or FIFO drain, status word rebuilt each cycle
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
            cpu_rdata <= '0;
        end else begin
            cpu_rdata <= mem[cpu_addr];
            if (pop) begin
                mem[h_addr] <= h_data;
            end
            if (cpu_we) begin
                mem[cpu_addr] <= cpu_wdata;
            end
            mem[A_ST] <= {{(DATA_W-2){1'b0}}, st_nxt};
        end
    end

    // Result return: CPU write to the result word loads and flags it
    always_ff @(posedge CLK_100MHZ or negedge reset) begin
        if (!reset) begin
            calc_rdata        <= '0;
            calc_result_valid <= 1'b0;
        end else if (cpu_we && cpu_addr == A_RES) begin
            calc_rdata        <= cpu_wdata;
            calc_result_valid <= 1'b1;
        end else if (rd_rise) begin
            calc_result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_calc_mem_bridge.sv
// Self-checking bench for calc_mem_bridge: directed table, corner
// sequences and randomized traffic against a queue-based model.
module tb_calc_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        calc_we;
    logic [32:0] calc_addr;
    logic [31:0] calc_wdata;
    logic        calc_rd_req;
    logic [31:0] calc_rdata;
    logic        calc_result_valid;
    logic [3:0]  cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_pass;
    int n_total;

    calc_mem_bridge dut (
        .CLK_100MHZ        (clk),
        .reset             (rst_n),
        .calc_we           (calc_we),
        .calc_addr         (calc_addr),
        .calc_wdata        (calc_wdata),
        .calc_rd_req       (calc_rd_req),
        .calc_rdata        (calc_rdata),
        .calc_result_valid (calc_result_valid),
        .cpu_addr          (cpu_addr),
        .cpu_we            (cpu_we),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .fifo_count        (fifo_count),
        .overflow          (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mailbox array, pending-write queue, flags
    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_mem [16];
    logic [1:0]  m_st;
    logic        m_valid;
    logic [31:0] m_res;
    logic [31:0] m_cpu_rd;
    logic        m_ovf;
    logic        m_pwe;
    logic        m_prd;

    function automatic logic [31:0] m_word(input logic [3:0] a);
        return (a == 4'd15) ? {30'd0, m_st} : m_mem[a];
    endfunction

    task automatic m_store(input logic [3:0] a, input logic [31:0] d);
        if (a == 4'd15) m_st = d[1:0];
        else m_mem[a] = d;
    endtask

    task automatic m_reset();
        m_q.delete();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_st = '0;
        m_valid = 1'b0;
        m_res = '0;
        m_cpu_rd = '0;
        m_ovf = 1'b0;
        m_pwe = 1'b0;
        m_prd = 1'b0;
    endtask

    task automatic m_step();
        bit   rw;
        bit   rr;
        bit   pop;
        int   sz;
        ent_t e;
        rw = calc_we && !m_pwe;
        rr = calc_rd_req && !m_prd;
        m_pwe = calc_we;
        m_prd = calc_rd_req;
        sz = m_q.size();
        pop = (sz > 0) && !cpu_we;
        m_cpu_rd = m_word(cpu_addr);
        e.a = '0;
        e.d = '0;
        if (pop) begin
            e = m_q.pop_front();
            m_store(e.a, e.d);
        end
        if (cpu_we) m_store(cpu_addr, cpu_wdata);
        if (rr) begin
            m_st[1] = 1'b0;
            m_valid = 1'b0;
        end
        if (cpu_we && cpu_addr == 4'd3) begin
            m_st[1] = 1'b1;
            m_valid = 1'b1;
            m_res = cpu_wdata;
        end
        if (pop && e.a == 4'd2) m_st[0] = 1'b1;
        if (rw) begin
            if (sz < 4 || pop) begin
                ent_t n;
                n.a = calc_addr[3:0];
                n.d = calc_wdata;
                m_q.push_back(n);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      nm, act, exp, $time);
    endtask

    // One clock: advance model on the edge, compare #1 later
    task automatic tick();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_step();
        #1;
        chk("m_cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("m_calc_rdata", calc_rdata, m_res);
        chk("m_valid", 32'(calc_result_valid), 32'(m_valid));
        chk("m_fifo_count", 32'(fifo_count), 32'(m_q.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] v);
        cpu_we = 1'b0;
        cpu_addr = a;
        tick();
        v = cpu_rdata;
    endtask

    task automatic calc_write(input logic [3:0] a, input logic [31:0] d);
        calc_addr = {29'h0ABCDEF1, a};
        calc_wdata = d;
        calc_we = 1'b1;
        repeat (4) tick();
        calc_we = 1'b0;
        repeat (4) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_calc_rdata"}, calc_rdata, 32'd0);
        chk({tag, "_valid"}, 32'(calc_result_valid), 32'd0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    typedef struct {
        logic        cwe;
        logic [3:0]  ca;
        logic [31:0] cd;
        logic        rd;
        logic        ev;
        logic [31:0] er;
        logic [31:0] ecr;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [31:0] v;
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        calc_we = 1'b0;
        calc_addr = '0;
        calc_wdata = '0;
        calc_rd_req = 1'b0;
        cpu_addr = '0;
        cpu_we = 1'b0;
        cpu_wdata = '0;
        m_reset();

        // Result path table: cpu_we, addr, data, rd_req -> valid, rdata, cpu_rdata
        tbl[0]  = '{1'b1, 4'd3,  32'h0000000F, 1'b0, 1'b1, 32'h0F, 32'h0};
        tbl[1]  = '{1'b0, 4'd15, 32'h0,        1'b0, 1'b1, 32'h0F, 32'h2};
        tbl[2]  = '{1'b0, 4'd15, 32'h0,        1'b1, 1'b0, 32'h0F, 32'h2};
        tbl[3]  = '{1'b0, 4'd15, 32'h0,        1'b1, 1'b0, 32'h0F, 32'h0};
        tbl[4]  = '{1'b1, 4'd3,  32'h00000022, 1'b0, 1'b1, 32'h22, 32'h0F};
        tbl[5]  = '{1'b1, 4'd3,  32'h00000033, 1'b1, 1'b1, 32'h33, 32'h22};
        tbl[6]  = '{1'b0, 4'd15, 32'h0,        1'b1, 1'b1, 32'h33, 32'h2};
        tbl[7]  = '{1'b0, 4'd15, 32'h0,        1'b0, 1'b1, 32'h33, 32'h2};
        tbl[8]  = '{1'b1, 4'd15, 32'h0,        1'b0, 1'b1, 32'h33, 32'h2};
        tbl[9]  = '{1'b0, 4'd15, 32'h0,        1'b0, 1'b1, 32'h33, 32'h0};
        tbl[10] = '{1'b1, 4'd15, 32'hFFFFFFFD, 1'b0, 1'b1, 32'h33, 32'h0};
        tbl[11] = '{1'b0, 4'd15, 32'h0,        1'b0, 1'b1, 32'h33, 32'h1};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            cpu_we = tbl[i].cwe;
            cpu_addr = tbl[i].ca;
            cpu_wdata = tbl[i].cd;
            calc_rd_req = tbl[i].rd;
            tick();
            chk($sformatf("tbl%0d_valid", i),
                32'(calc_result_valid), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_rdata", i), calc_rdata, tbl[i].er);
            chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].ecr);
        end
        cpu_we = 1'b0;
        calc_rd_req = 1'b0;
        tick();

        // Held strobe: one write, word 0 readable 2 cycles after the rise
        cpu_addr = 4'd0;
        calc_addr = {29'h1FFFFFFF, 4'd0};
        calc_wdata = 32'h7;
        calc_we = 1'b1;
        tick();
        chk("hold_count_after_rise", 32'(fifo_count), 32'd1);
        tick();
        chk("hold_count_drained", 32'(fifo_count), 32'd0);
        chk("hold_word0_prewrite", cpu_rdata, 32'd0);
        tick();
        chk("hold_word0", cpu_rdata, 32'd7);
        tick();
        chk("hold_single_write", 32'(fifo_count), 32'd0);
        calc_we = 1'b0;
        tick();

        // Spaced writes to operand words and START
        cpu_write(4'd15, 32'd0);
        calc_write(4'd0, 32'd5);
        calc_write(4'd1, 32'hA);
        cpu_read(4'd15, v);
        chk("start_before_opb", v, 32'h0);
        calc_write(4'd2, 32'd3);
        cpu_read(4'd15, v);
        chk("start_after_opb", v, 32'h1);
        cpu_read(4'd0, v);
        chk("word0", v, 32'd5);
        cpu_read(4'd1, v);
        chk("word1", v, 32'hA);
        cpu_read(4'd2, v);
        chk("word2", v, 32'd3);

        // CPU holds the port; fifth back-to-back write overflows
        cpu_we = 1'b1;
        cpu_addr = 4'd9;
        cpu_wdata = 32'h99;
        for (int i = 0; i < 5; i++) begin
            calc_addr = {29'd0, 4'(4 + i)};
            calc_wdata = 32'h40 + 32'(i) * 32'h10;
            calc_we = 1'b1;
            tick();
            calc_we = 1'b0;
            tick();
        end
        chk("ovf_count_full", 32'(fifo_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        cpu_we = 1'b0;
        repeat (5) tick();
        chk("ovf_drained", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cpu_read(4'(4 + i), v);
            chk($sformatf("ovf_word%0d", 4 + i), v, 32'h40 + 32'(i) * 32'h10);
        end
        cpu_read(4'd8, v);
        chk("ovf_dropped_word8", v, 32'd0);
        cpu_read(4'd9, v);
        chk("ovf_cpu_word9", v, 32'h99);

        // Asynchronous reset with three writes pending
        cpu_we = 1'b1;
        cpu_addr = 4'd9;
        for (int i = 0; i < 3; i++) begin
            calc_addr = {29'd0, 4'(10 + i)};
            calc_wdata = 32'hA0 + 32'(i);
            calc_we = 1'b1;
            tick();
            calc_we = 1'b0;
            tick();
        end
        chk("rst_count3", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        cpu_we = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            cpu_read(4'(10 + i), v);
            chk($sformatf("rst_stale_word%0d", 10 + i), v, 32'd0);
        end

        // Strobe already high at reset release counts as a rise
        calc_addr = {29'd0, 4'd13};
        calc_wdata = 32'hD;
        calc_we = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_rise_count", 32'(fifo_count), 32'd1);
        tick();
        cpu_read(4'd13, v);
        chk("rel_rise_word13", v, 32'hD);
        calc_we = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) calc_we = ~calc_we;
            if (!calc_we) begin
                calc_addr = {1'($urandom), $urandom};
                calc_wdata = $urandom;
            end
            if ($urandom_range(0, 4) == 0) calc_rd_req = ~calc_rd_req;
            cpu_we = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 3))
                0: cpu_addr = 4'd3;
                1: cpu_addr = 4'd15;
                default: cpu_addr = 4'($urandom);
            endcase
            cpu_wdata = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
